// File: rtl/multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multicycle control unit: opcode values, ALU
// operation codes, the controller state enum and the instruction class enum
// produced by opcode_decode.
// ----------------------------------------------------------------------------
package multicycle_control_pkg;

    // Opcode field values (4-bit instruction encoding).
    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU operation codes.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;

    // Controller states.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Instruction classes that steer the FSM.
    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// ----------------------------------------------------------------------------
// opcode_decode
// Purely combinational per-opcode decode: classifies the opcode and supplies
// the ALU operation and ALU source select used in EXEC.
// Ports:
//   i_op     - opcode (from the latched opcode register)
//   o_cls    - instruction class (rtype/load/store/branch/halt/illegal)
//   o_aluop  - ALU operation code
//   o_alusrc - 1 selects the sign-extended offset (lw/sw)
// ----------------------------------------------------------------------------
module opcode_decode
    import multicycle_control_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 3
) (
    input  logic [OP_W-1:0]    i_op,
    output op_class_t          o_cls,
    output logic [ALUOP_W-1:0] o_aluop,
    output logic               o_alusrc
);

    always_comb begin
        o_cls    = CLS_ILLEGAL;
        o_aluop  = '0;
        o_alusrc = 1'b0;
        case (i_op)
            OP_W'(OP_ADD):  begin o_cls = CLS_RTYPE;  o_aluop = ALUOP_W'(ALU_ADD); end
            OP_W'(OP_AND):  begin o_cls = CLS_RTYPE;  o_aluop = ALUOP_W'(ALU_AND); end
            OP_W'(OP_OR):   begin o_cls = CLS_RTYPE;  o_aluop = ALUOP_W'(ALU_OR);  end
            OP_W'(OP_SLT):  begin o_cls = CLS_RTYPE;  o_aluop = ALUOP_W'(ALU_SLT); end
            OP_W'(OP_SUB):  begin o_cls = CLS_RTYPE;  o_aluop = ALUOP_W'(ALU_SUB); end
            // bne compares by subtraction; the zero flag decides the branch.
            OP_W'(OP_BNE):  begin o_cls = CLS_BRANCH; o_aluop = ALUOP_W'(ALU_SUB); end
            // Loads/stores add the offset to the base register.
            OP_W'(OP_LW):   begin o_cls = CLS_LOAD;   o_aluop = ALUOP_W'(ALU_ADD); o_alusrc = 1'b1; end
            OP_W'(OP_SW):   begin o_cls = CLS_STORE;  o_aluop = ALUOP_W'(ALU_ADD); o_alusrc = 1'b1; end
            OP_W'(OP_HALT): begin o_cls = CLS_HALT; end
            default:        begin o_cls = CLS_ILLEGAL; end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Control FSM for a multicycle datapath: FETCH -> DECODE -> EXEC -> [MEM] ->
// [WB] -> FETCH, plus a terminal HALT state. Outputs decode the current state
// and the latched opcode only; op itself never reaches an output directly.
//
// Memory handshake: memread/memwrite are held as a request for as long as the
// FSM sits in FETCH or MEM; the access completes in the cycle where
// mem_ready=1 is sampled together with the request, and the FSM advances on
// that rising edge. mem_ready is ignored in all other states.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   op            - opcode of the fetched instruction (valid while irwrite=1)
//   zero          - ALU zero flag (used in EXEC for bne)
//   mem_ready     - memory completion
//   pcwrite       - PC <= PC+1 (FETCH completion)
//   pcwrite_br    - PC <= branch target (bne taken)
//   irwrite       - instruction register load
//   alusrc        - ALU B operand select
//   regwrite      - register file write
//   memread       - memory read request (FETCH, lw MEM)
//   memwrite      - memory write request (sw MEM)
//   memtoreg      - write-back source select (1 = ALU)
//   regdest       - destination register select (1 = rt)
//   aluop         - ALU operation
//   illegal       - one-cycle pulse on an undefined opcode
//   halted        - high in HALT
//   retired       - completed instruction count (wraps)
// ----------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               pcwrite_br,
    output logic               irwrite,
    output logic               alusrc,
    output logic               regwrite,
    output logic               memread,
    output logic               memwrite,
    output logic               memtoreg,
    output logic               regdest,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    state_t              r_state;
    state_t              w_next;
    logic [OP_W-1:0]     r_op;
    logic [CNT_W-1:0]    r_retired;

    op_class_t           w_cls;
    logic [ALUOP_W-1:0]  w_dec_aluop;
    logic                w_dec_alusrc;

    logic                w_latch;
    logic                w_retire;
    logic                w_pcwrite;
    logic                w_irwrite;
    logic                w_memread;
    logic                w_memwrite;

    opcode_decode #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .i_op     (r_op),
        .o_cls    (w_cls),
        .o_aluop  (w_dec_aluop),
        .o_alusrc (w_dec_alusrc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_op      <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_op <= op;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_retire    = 1'b0;
        w_pcwrite   = 1'b0;
        w_irwrite   = 1'b0;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        pcwrite_br  = 1'b0;
        alusrc      = 1'b0;
        regwrite    = 1'b0;
        memtoreg    = 1'b0;
        regdest     = 1'b0;
        aluop       = '0;
        illegal     = 1'b0;
        halted      = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                if (mem_ready) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_latch   = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_cls)
                    CLS_HALT:    w_next = S_HALT;
                    CLS_ILLEGAL: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                    default:     w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                aluop  = w_dec_aluop;
                alusrc = w_dec_alusrc;
                case (w_cls)
                    CLS_RTYPE:  w_next = S_WB;
                    CLS_LOAD,
                    CLS_STORE:  w_next = S_MEM;
                    CLS_BRANCH: begin
                        // Taken when the compared registers differ.
                        pcwrite_br = ~zero;
                        w_retire   = 1'b1;
                        w_next     = S_FETCH;
                    end
                    default:    w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_memread  = (w_cls == CLS_LOAD);
                w_memwrite = (w_cls == CLS_STORE);
                if (mem_ready) begin
                    if (w_cls == CLS_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                memtoreg = (w_cls == CLS_RTYPE);
                regdest  = (w_cls == CLS_LOAD);
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset holds the state in FETCH, whose request/handshake strobes would
    // otherwise be live; mask them so a reset abandons any access at once.
    assign memread  = w_memread  & ~rst;
    assign memwrite = w_memwrite & ~rst;
    assign pcwrite  = w_pcwrite  & ~rst;
    assign irwrite  = w_irwrite  & ~rst;
    assign retired  = r_retired;

endmodule
